serial_block_rx: RTL and testbench

//  Serial front end of the AES datapath. Receives a UART 8N1 byte stream and assembles
//  one 128-bit plaintext block followed by one 128-bit key. When SerialReadEn is high and
//  all 32 bytes are captured, raises SerialReadRy to the Controller, which then enables key expansion.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 95 +++++++++
 rtl/serial_block_rx.sv | 63 ++++++
 tb/tb_serial_block_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants, the UART receiver state encoding and a block-shift helper.
package aes_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_state_e;

  // Appends a byte at the LSB end so the first byte received ends up in the top byte.
  function automatic logic [AES_BLOCK_W-1:0] shift_in_byte(input logic [AES_BLOCK_W-1:0] blk,
                                                           input logic [7:0] b);
    return {blk[AES_BLOCK_W-9:0], b};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: input synchroniser, baud counter and bit FSM.
module uart_rx_byte
  import aes_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  uart_state_e   state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;

  // Two-flop synchroniser on the asynchronous line; deliberately not reset.
  always_ff @(posedge clk) begin
    rx_meta_r <= rx;
    rx_sync_r <= rx_meta_r;
  end

  // Bit FSM; every sample point is counted from the detected falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_r <= 1'b1;
      state_r   <= RX_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_prev_r <= rx_sync_r;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r <= '0;
          if (rx_prev_r && !rx_sync_r) state_r <= RX_START;
          else                         state_r <= RX_IDLE;
        end
        RX_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            state_r   <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_sync_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) state_r <= RX_STOP;
            else                   bit_idx_r <= bit_idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
            if (rx_sync_r) begin
              rx_byte  <= shift_r;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_block_rx.sv
// Serial front end of the AES datapath: collects a 16-byte plaintext block then a 16-byte key.
module serial_block_rx
  import aes_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BLOCK_BYTES  = AES_BLOCK_BYTES
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   SerialReadEn,
  input  logic                   Rx,
  output logic                   SerialReadRy,
  output logic [AES_BLOCK_W-1:0] DataOut,
  output logic [AES_BLOCK_W-1:0] KeyOut,
  output logic                   FrameErr
);

  localparam int CNT_W = $clog2(2 * BLOCK_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] KEY_FROM = CNT_W'(BLOCK_BYTES);

  logic [7:0]       rx_byte_s;
  logic             rx_valid_s;
  logic [CNT_W-1:0] count_r;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk       (Clk),
    .rst       (Rst),
    .rx        (Rx),
    .rx_byte   (rx_byte_s),
    .rx_valid  (rx_valid_s),
    .frame_err (FrameErr)
  );

  // Byte assembly; the ready flag doubles as the done bit and freezes both blocks while set.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      SerialReadRy <= 1'b0;
      DataOut      <= '0;
      KeyOut       <= '0;
      count_r      <= '0;
    end else if (SerialReadRy) begin
      if (!SerialReadEn) begin
        SerialReadRy <= 1'b0;
        count_r      <= '0;
      end else begin
        SerialReadRy <= 1'b1;
      end
    end else if (rx_valid_s && SerialReadEn) begin
      if (count_r < KEY_FROM) DataOut <= shift_in_byte(DataOut, rx_byte_s);
      else                    KeyOut  <= shift_in_byte(KeyOut, rx_byte_s);
      if (count_r == CNT_LAST) begin
        SerialReadRy <= 1'b1;
        count_r      <= '0;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: tb/tb_serial_block_rx.sv
// Randomised bench for serial_block_rx: a byte-level reference model feeds a scoreboard
// that a free-running monitor drains on every FrameErr pulse and every rising SerialReadRy.
module tb_serial_block_rx;

  localparam int CPB = 4;

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
  } blk_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         SerialReadEn = 1'b0;
  logic         Rx = 1'b1;
  logic         SerialReadRy;
  logic [127:0] DataOut;
  logic [127:0] KeyOut;
  logic         FrameErr;

  int   checks = 0;
  int   errors = 0;
  blk_t exp_q[$];
  int   ferr_exp = 0;

  logic [7:0] model_bytes[$];
  bit         model_ready = 1'b0;
  logic       ry_q = 1'b0;
  blk_t       last_blk;

  serial_block_rx #(.CLKS_PER_BIT(CPB), .BLOCK_BYTES(16)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .SerialReadEn (SerialReadEn),
    .Rx           (Rx),
    .SerialReadRy (SerialReadRy),
    .DataOut      (DataOut),
    .KeyOut       (KeyOut),
    .FrameErr     (FrameErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every FrameErr cycle and every ready rising edge must match a queued expectation.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (FrameErr) begin
        checks++;
        if (ferr_exp == 0) begin
          errors++;
          $display("FAIL frame_err: got unexpected pulse expected none");
        end else begin
          ferr_exp--;
        end
      end
      if (SerialReadRy && !ry_q) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ready_rise: got unexpected ready expected none");
        end else begin
          blk_t e;
          e = exp_q.pop_front();
          check("block_data", DataOut, e.data);
          check("block_key", KeyOut, e.key);
        end
      end
    end
    ry_q <= SerialReadRy;
  end

  // Model: 32 accepted bytes form a block; the first 16 are plaintext, first byte on top.
  function automatic blk_t build_block();
    blk_t b;
    b.data = '0;
    b.key  = '0;
    for (int i = 0; i < 16; i++) b.data = {b.data[119:0], model_bytes[i]};
    for (int i = 16; i < 32; i++) b.key = {b.key[119:0], model_bytes[i]};
    return b;
  endfunction

  // Frame: start bit leaves after edge k; the DUT's stop sample lands on edge k+41
  // (2 sync flops, 1 edge detect, CPB/2 to mid start, 9*CPB to the stop bit).
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    bit completes;
    fr = {stop_ok, b, 1'b0};
    completes = 1'b0;
    if (!stop_ok) begin
      ferr_exp++;
    end else if (SerialReadEn && !model_ready) begin
      model_bytes.push_back(b);
      if (model_bytes.size() == 32) begin
        last_blk = build_block();
        exp_q.push_back(last_blk);
        model_ready = 1'b1;
        completes = 1'b1;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1 Rx = fr[i];
      repeat (CPB - 1) @(posedge Clk);
    end
    @(posedge Clk); #1 Rx = 1'b1;
    @(posedge Clk); #1;
    if (completes) check("ready_lat1", {127'd0, SerialReadRy}, 128'd0);
    @(posedge Clk); #1;
    if (completes) check("ready_lat2", {127'd0, SerialReadRy}, 128'd1);
    repeat ($urandom_range(0, 3)) @(posedge Clk);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom()), 1'b1);
  endtask

  task automatic release_ready();
    @(posedge Clk); #1 SerialReadEn = 1'b0;
    if (model_ready) begin
      model_ready = 1'b0;
      model_bytes.delete();
    end
    @(posedge Clk); #1;
    check("release_ry", {127'd0, SerialReadRy}, 128'd0);
    check("release_data_kept", DataOut, last_blk.data);
    SerialReadEn = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    model_bytes.delete();
    model_ready = 1'b0;
    last_blk.data = '0;
    last_blk.key  = '0;
    check("rst_ry", {127'd0, SerialReadRy}, 128'd0);
    check("rst_data", DataOut, 128'd0);
    check("rst_key", KeyOut, 128'd0);
    check("rst_ferr", {127'd0, FrameErr}, 128'd0);
  endtask

  initial begin
    repeat (4) @(posedge Clk);
    #1 SerialReadEn = 1'b1;
    pulse_reset();

    // Idle line for 1000 cycles must not produce ready.
    repeat (1000) @(posedge Clk);
    #1 check("idle_ry", {127'd0, SerialReadRy}, 128'd0);

    // Counting pattern against fixed constants.
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b1);
    check("count_data", DataOut, 128'h000102030405060708090A0B0C0D0E0F);
    check("count_key", KeyOut, 128'h101112131415161718191A1B1C1D1E1F);

    // A byte arriving while ready is consumed but changes nothing.
    send_byte(8'hAA, 1'b1);
    check("frozen_data", DataOut, 128'h000102030405060708090A0B0C0D0E0F);
    check("frozen_key", KeyOut, 128'h101112131415161718191A1B1C1D1E1F);
    check("frozen_ry", {127'd0, SerialReadRy}, 128'd1);
    release_ready();
    send_random(32);
    release_ready();

    // Bad stop bit: pulse only, count untouched.
    send_byte(8'h55, 1'b0);
    send_random(32);
    release_ready();

    // One-cycle glitch on the line.
    @(posedge Clk); #1 Rx = 1'b0;
    @(posedge Clk); #1 Rx = 1'b1;
    repeat (3 * CPB) @(posedge Clk);
    send_random(32);
    release_ready();

    // Enable dropped mid-collection: bytes dropped, count kept.
    send_random(10);
    @(posedge Clk); #1 SerialReadEn = 1'b0;
    send_random(2);
    @(posedge Clk); #1 SerialReadEn = 1'b1;
    send_random(22);
    release_ready();

    // Reset after 20 bytes; the following 32 fill from byte 0.
    send_random(20);
    pulse_reset();
    send_random(32);
    release_ready();

    repeat (20) @(posedge Clk);
    #1;
    check("left_blocks", 128'(exp_q.size()), 128'd0);
    check("left_ferr", 128'(ferr_exp), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
